mine_gen: RTL and testbench
===========================

MINE_GEN -- requirements
Module: mine_gen

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-002 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have port start, input, 1 bit: single-cycle request to generate a new board.
REQ-004 The block SHALL have port seed, input, 16 bits: LFSR seed, sampled on an accepted start.
REQ-005 The block SHALL have port num_mines, input, 6 bits: requested mine count, sampled on an accepted start.
REQ-006 The block SHALL have port safe_tile, input, 6 bits: tile index that never receives a mine (first-click tile), sampled on an accepted start.
REQ-007 The block SHALL have port mine_map, output, 64 bits: bit i = 1 means tile i holds a mine; it feeds the adjacency-count stage.
REQ-008 The block SHALL have port mine_count, output, 6 bits: number of mines placed so far.
REQ-009 The block SHALL have port busy, output, 1 bit: high in SEED and PLACE.
REQ-010 The block SHALL have port done, output, 1 bit: level signal, high in DONE; downstream holds its own reset low until done = 1.

Function
REQ-011 The block SHALL implement four states: IDLE, SEED, PLACE, DONE.
REQ-012 In IDLE or DONE, start = 1 SHALL move the state to SEED on the next edge and latch seed, num_mines and safe_tile.
REQ-013 In SEED or PLACE, start SHALL be ignored.
REQ-014 In SEED, the block SHALL clear mine_map to 0 and mine_count to 0.
REQ-015 In SEED, the block SHALL load the LFSR with the latched seed; a seed of 16'h0000 SHALL load 16'hACE1 instead.
REQ-016 SEED SHALL go to PLACE if the latched num_mines is non-zero, and otherwise go directly to DONE.
REQ-017 The LFSR SHALL be 16-bit Fibonacci: next = {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
REQ-018 The LFSR SHALL advance on every PLACE cycle.
REQ-019 On each PLACE cycle, the candidate SHALL be lfsr[5:0] (the current value, before advancing).
REQ-020 On each PLACE cycle, if the candidate is not equal to safe_tile and mine_map[candidate] = 0, the block SHALL set that bit and increment mine_count; otherwise the cycle SHALL be a rejected no-op.
REQ-021 When the increment makes mine_count equal the latched num_mines, the next state SHALL be DONE; otherwise it SHALL stay PLACE.
REQ-022 At most one mine SHALL be placed per cycle.
REQ-023 Total latency from start SHALL be num_mines + 2 + (number of rejected cycles) clocks.
REQ-024 num_mines = 63 SHALL be legal; the result SHALL be all tiles except safe_tile.
REQ-025 Termination SHALL be guaranteed, because the LFSR period of 65535 visits every 6-bit low-order value.
REQ-026 mine_map SHALL change only in SEED and PLACE.
REQ-027 mine_map SHALL hold stable in DONE and IDLE.
REQ-028 done SHALL deassert on the cycle the state enters SEED.
REQ-029 mine_map SHALL never have the safe_tile bit set.
REQ-030 mine_count SHALL always equal the popcount of mine_map.

Reset
REQ-031 While rst = 0, the state SHALL be IDLE.
REQ-032 While rst = 0, mine_map SHALL be 0, mine_count SHALL be 0, busy SHALL be 0 and done SHALL be 0.
REQ-033 While rst = 0, the LFSR SHALL be 16'hACE1 and the latched inputs SHALL be 0.
REQ-034 Reset asserted mid-PLACE SHALL abort generation immediately (asynchronously).
REQ-035 After reset is released mid-PLACE, the block SHALL wait in IDLE for a new start.

Verification
REQ-036 Scenario — zero mines: start with num_mines = 0 and seed = 16'h1234. Required: done = 1 exactly 2 cycles after start, mine_map = 0, mine_count = 0.
REQ-037 Scenario — zero seed: start with seed = 0 and num_mines = 1. Required: the LFSR holds 16'hACE1 in the first PLACE cycle; tile 33 (6'h21) is placed in that cycle unless safe_tile = 33.
REQ-038 Scenario — normal board: start with num_mines = 10, seed = 16'h1234, safe_tile = 27. Required: done asserts, popcount(mine_map) = 10, mine_count = 10, mine_map[27] = 0, and the map stays stable for 100 cycles afterwards.
REQ-039 Scenario — full board: start with num_mines = 63, safe_tile = 0. Required: mine_map = 64'hFFFF_FFFF_FFFF_FFFE at done.
REQ-040 Scenario — start while busy: pulse start with different inputs during PLACE. Required: the result matches an unperturbed run with the original inputs.
REQ-041 Scenario — restart from DONE: pulse start again from DONE. Required: the map clears, done drops the next cycle, and a new board is generated.
REQ-042 Scenario — reset mid-operation: drive rst low during PLACE. Required: mine_map = 0, busy = 0, done = 0 immediately; the block is in IDLE after release.

Source files
------------

// File: rtl/mine_gen.sv
// Minefield generator: places num_mines mines on a 64-tile board with a 16-bit LFSR,
// never on safe_tile; mine_map/mine_count feed the adjacency-count stage.
module mine_gen (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] seed,
   input  logic [5:0]  num_mines,
   input  logic [5:0]  safe_tile,
   output logic [63:0] mine_map,
   output logic [5:0]  mine_count,
   output logic        busy,
   output logic        done,
   output logic [1:0]  state_dbg
);

   localparam logic [15:0] LFSR_INIT = 16'hACE1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SEED  = 2'd1,
      S_PLACE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t      state_q;
   logic [15:0] lfsr_q;
   logic [15:0] seed_q;
   logic [5:0]  num_q;
   logic [5:0]  safe_q;
   logic [63:0] map_q;
   logic [5:0]  count_q;
   logic        busy_q;
   logic        done_q;

   logic [15:0] lfsr_d;
   logic [5:0]  cand;
   logic        cand_ok;
   logic [5:0]  count_d;
   logic [63:0] cand_bit;

   assign lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   assign cand     = lfsr_q[5:0];
   assign cand_bit = 64'd1 << cand;
   assign cand_ok  = (cand != safe_q) && !map_q[cand];
   assign count_d  = count_q + 6'd1;

   // start is a one-cycle request: accepted only in IDLE or DONE, dropped silently in SEED/PLACE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         lfsr_q  <= LFSR_INIT;
         seed_q  <= 16'd0;
         num_q   <= 6'd0;
         safe_q  <= 6'd0;
         map_q   <= 64'd0;
         count_q <= 6'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state_q <= S_SEED;
                  seed_q  <= seed;
                  num_q   <= num_mines;
                  safe_q  <= safe_tile;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
               end
            end
            S_SEED: begin
               map_q   <= 64'd0;
               count_q <= 6'd0;
               // An all-zero LFSR would lock up, so a zero seed is replaced.
               lfsr_q  <= (seed_q == 16'd0) ? LFSR_INIT : seed_q;
               if (num_q == 6'd0) begin
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  state_q <= S_PLACE;
               end
            end
            S_PLACE: begin
               lfsr_q <= lfsr_d;
               if (cand_ok) begin
                  map_q   <= map_q | cand_bit;
                  count_q <= count_d;
                  if (count_d == num_q) begin
                     state_q <= S_DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end
               end
            end
         endcase
      end
   end

   assign mine_map   = map_q;
   assign mine_count = count_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign state_dbg  = state_q;

   // During SEED the previous board is still visible against the newly latched safe tile.
   a_safe_clear: assert property (@(posedge clk) disable iff (!rst)
      (state_q != S_SEED) |-> !map_q[safe_q]);
   a_count_pop: assert property (@(posedge clk) disable iff (!rst)
      count_q == 6'($countones(map_q)));
   a_busy_done: assert property (@(posedge clk) disable iff (!rst)
      !(busy_q && done_q));

endmodule

// File: tb/tb_mine_gen.sv
// Directed bench for mine_gen: a vector table of boards with hand-computed results
// plus sequences for busy-start, restart, stability and mid-PLACE reset.
module tb_mine_gen;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [15:0] seed = 16'd0;
   logic [5:0]  num_mines = 6'd0;
   logic [5:0]  safe_tile = 6'd0;
   logic [63:0] mine_map;
   logic [5:0]  mine_count;
   logic        busy;
   logic        done;
   logic [1:0]  state_dbg;

   int n_cmp = 0;
   int n_err = 0;

   mine_gen dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .seed       (seed),
      .num_mines  (num_mines),
      .safe_tile  (safe_tile),
      .mine_map   (mine_map),
      .mine_count (mine_count),
      .busy       (busy),
      .done       (done),
      .state_dbg  (state_dbg)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] seed;
      logic [5:0]  num;
      logic [5:0]  safe;
      logic        chk_map;
      logic [63:0] exp_map;
      int          exp_lat;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference board generator, used where the result is too long to work out by hand.
   function automatic void model(input logic [15:0] s, input logic [5:0] n, input logic [5:0] sf,
                                 output logic [63:0] m, output int lat);
      logic [15:0] l;
      int c;
      l = (s == 16'd0) ? 16'hACE1 : s;
      m = 64'd0;
      c = 0;
      lat = 2;
      while (c < int'(n) && lat < 60000) begin
         if (l[5:0] != sf && !m[l[5:0]]) begin
            m[l[5:0]] = 1'b1;
            c++;
         end
         l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
         lat++;
      end
   endfunction

   // Called at #1 after an edge; returns at #1 after the edge where done was first seen.
   task automatic run_board(input string tag, input logic [15:0] s, input logic [5:0] n,
                            input logic [5:0] sf, input logic chk_map, input logic [63:0] exp_map,
                            input int exp_lat, input logic perturb, output logic [63:0] map_o);
      logic [63:0] mm;
      int ml;
      int nc;
      model(s, n, sf, mm, ml);
      if (chk_map) mm = exp_map;
      if (exp_lat != 0) ml = exp_lat;
      seed = s;
      num_mines = n;
      safe_tile = sf;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      nc = 1;
      check({tag, " busy_in_seed"}, 64'(busy), 64'd1);
      check({tag, " done_drop"}, 64'(done), 64'd0);
      while (!done && nc < 5000) begin
         if (perturb && nc == 4) begin
            seed = ~s;
            num_mines = n ^ 6'h15;
            safe_tile = sf + 6'd1;
            start = 1'b1;
         end
         @(posedge clk);
         #1;
         start = 1'b0;
         nc++;
         if (nc == 2) check({tag, " map_cleared"}, mine_map, 64'd0);
         check({tag, " count_popcount"}, 64'(mine_count), 64'($countones(mine_map)));
         check({tag, " safe_bit"}, 64'(mine_map[sf]), 64'd0);
      end
      check({tag, " latency"}, 64'(nc), 64'(ml));
      check({tag, " map"}, mine_map, mm);
      check({tag, " count"}, 64'(mine_count), 64'(n));
      check({tag, " busy_end"}, 64'(busy), 64'd0);
      check({tag, " done_end"}, 64'(done), 64'd1);
      map_o = mine_map;
   endtask

   initial begin
      vec_t vecs[9];
      logic [63:0] got;
      logic [63:0] ref_map;
      int ref_lat;

      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[9];
      logic [63:0] got;
      logic [63:0] saved;

      vecs[0] = '{16'h1234, 6'd0,  6'd27, 1'b1, 64'd0,                  2};
      vecs[1] = '{16'h0000, 6'd1,  6'd0,  1'b1, 64'h0000_0002_0000_0000, 3};
      vecs[2] = '{16'h0000, 6'd1,  6'd33, 1'b1, 64'h0000_0000_0000_0008, 4};
      vecs[3] = '{16'h0000, 6'd2,  6'd0,  1'b1, 64'h0000_0002_0000_0008, 4};
      vecs[4] = '{16'h0001, 6'd1,  6'd5,  1'b1, 64'h0000_0000_0000_0002, 3};
      vecs[5] = '{16'h0001, 6'd1,  6'd1,  1'b1, 64'h0000_0000_0000_0004, 4};
      vecs[6] = '{16'hBEEF, 6'd63, 6'd0,  1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 0};
      vecs[7] = '{16'h1234, 6'd10, 6'd27, 1'b0, 64'd0,                  0};
      vecs[8] = '{16'h8001, 6'd63, 6'd40, 1'b1, 64'hFFFF_FEFF_FFFF_FFFF, 0};

      repeat (3) @(posedge clk);
      #1;
      check("rst map", mine_map, 64'd0);
      check("rst count", 64'(mine_count), 64'd0);
      check("rst busy", 64'(busy), 64'd0);
      check("rst done", 64'(done), 64'd0);
      check("rst state", 64'(state_dbg), 64'd0);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("idle state", 64'(state_dbg), 64'd0);

      for (int i = 0; i < 9; i++) begin
         run_board($sformatf("vec%0d", i), vecs[i].seed, vecs[i].num, vecs[i].safe,
                   vecs[i].chk_map, vecs[i].exp_map, vecs[i].exp_lat, 1'b0, got);
      end

      // Normal board, then the map must hold for 100 idle cycles in DONE.
      run_board("normal", 16'h1234, 6'd10, 6'd27, 1'b0, 64'd0, 0, 1'b0, saved);
      check("normal bit27", 64'(saved[27]), 64'd0);
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #1;
         check("stable map", mine_map, saved);
         check("stable done", 64'(done), 64'd1);
      end

      // A start pulse with different inputs during PLACE must not disturb the board.
      run_board("busy_start", 16'h1234, 6'd10, 6'd27, 1'b0, 64'd0, 0, 1'b1, got);
      check("busy_start same_as_normal", got, saved);

      // Reset in the middle of PLACE aborts immediately and parks in IDLE.
      seed = 16'h1234;
      num_mines = 6'd63;
      safe_tile = 6'd0;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("mid busy", 64'(busy), 64'd1);
      #2;
      rst = 1'b0;
      #1;
      check("abort map", mine_map, 64'd0);
      check("abort count", 64'(mine_count), 64'd0);
      check("abort busy", 64'(busy), 64'd0);
      check("abort done", 64'(done), 64'd0);
      check("abort state", 64'(state_dbg), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("post state", 64'(state_dbg), 64'd0);
      check("post busy", 64'(busy), 64'd0);
      check("post done", 64'(done), 64'd0);
      check("post map", mine_map, 64'd0);
      run_board("recover", 16'h0000, 6'd1, 6'd0, 1'b1, 64'h0000_0002_0000_0000, 3, 1'b0, got);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
